// File: rtl/mac_tile_ctrl.sv
// Sequencer for one 8x8 MAC tile: weight fetch/load/drain, activation fetch/execute, output counting.
// Optional watchdog on the output wait is enabled by defining MAC_TILE_CTRL_WATCHDOG_EN.
module mac_tile_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_bw  = 8,
    parameter int addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [len_bw-1:0]  num_act,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] x_base,
    input  logic               ofifo_full,
    input  logic [col-1:0]     array_valid,
    output logic               busy,
    output logic               done,
    output logic               sram_cen,
    output logic [addr_bw-1:0] sram_addr,
    output logic               l0_wr,
    output logic               l0_rd,
    output logic [1:0]         inst_w,
    output logic [len_bw-1:0]  psum_cnt,
    output logic               err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH_W  = 3'd1;
    localparam logic [2:0] S_LOAD_W   = 3'd2;
    localparam logic [2:0] S_DRAIN_W  = 3'd3;
    localparam logic [2:0] S_FETCH_X  = 3'd4;
    localparam logic [2:0] S_EXEC     = 3'd5;
    localparam logic [2:0] S_WAIT_OUT = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    // The phase counter doubles as the issued-slot counter in EXEC.
    localparam logic [len_bw-1:0] col_last = len_bw'(col - 1);
    localparam logic [len_bw-1:0] row_last = len_bw'(row - 1);

`ifdef MAC_TILE_CTRL_WATCHDOG_EN
    localparam int              wd_lim  = 2 * (row + col);
    localparam int              wd_bw   = $clog2(wd_lim + 1);
    localparam logic [wd_bw-1:0] wd_last = wd_bw'(wd_lim - 1);
    logic [wd_bw-1:0] wd_q, wd_d;
`endif

    logic [2:0]         state_q, state_d;
    logic [len_bw-1:0]  cnt_q, cnt_d;
    logic [len_bw-1:0]  num_act_q, num_act_d;
    logic [addr_bw-1:0] x_base_q, x_base_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sram_cen_q, sram_cen_d;
    logic [addr_bw-1:0] sram_addr_q, sram_addr_d;
    logic               l0_wr_q, l0_wr_d;
    logic               l0_rd_q, l0_rd_d;
    logic [1:0]         inst_w_q, inst_w_d;
    logic [len_bw-1:0]  psum_q, psum_d;
    logic               err_q, err_d;
    logic               psum_inc_s;
    logic               issue_s;
    logic               unused_valid_s;

    assign unused_valid_s = ^array_valid;
    assign issue_s        = ~ofifo_full;

    // Next-state and next-output computation for the tile sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        num_act_d   = num_act_q;
        x_base_d    = x_base_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sram_cen_d  = sram_cen_q;
        sram_addr_d = sram_addr_q;
        l0_wr_d     = ~sram_cen_q;
        l0_rd_d     = l0_rd_q;
        inst_w_d    = inst_w_q;
        err_d       = 1'b0;
`ifdef MAC_TILE_CTRL_WATCHDOG_EN
        wd_d        = wd_q;
`endif

        psum_inc_s = array_valid[col-1] && (psum_q < num_act_q) &&
                     ((state_q == S_EXEC) || (state_q == S_WAIT_OUT));
        if (psum_inc_s) begin
            psum_d = psum_q + len_bw'(1);
        end else begin
            psum_d = psum_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_act_d = num_act;
                    x_base_d  = x_base;
                    psum_d    = {len_bw{1'b0}};
                    if (num_act != {len_bw{1'b0}}) begin
                        state_d     = S_FETCH_W;
                        busy_d      = 1'b1;
                        sram_cen_d  = 1'b0;
                        sram_addr_d = w_base;
                        cnt_d       = {len_bw{1'b0}};
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH_W: begin
                if (cnt_q == col_last) begin
                    state_d    = S_LOAD_W;
                    cnt_d      = {len_bw{1'b0}};
                    sram_cen_d = 1'b1;
                    inst_w_d   = 2'b01;
                    l0_rd_d    = 1'b1;
                end else begin
                    cnt_d       = cnt_q + len_bw'(1);
                    sram_addr_d = sram_addr_q + addr_bw'(1);
                end
            end
            S_LOAD_W: begin
                if (cnt_q == col_last) begin
                    state_d  = S_DRAIN_W;
                    cnt_d    = {len_bw{1'b0}};
                    inst_w_d = 2'b00;
                    l0_rd_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + len_bw'(1);
                end
            end
            S_DRAIN_W: begin
                if (cnt_q == row_last) begin
                    state_d     = S_FETCH_X;
                    cnt_d       = {len_bw{1'b0}};
                    sram_cen_d  = 1'b0;
                    sram_addr_d = x_base_q;
                end else begin
                    cnt_d = cnt_q + len_bw'(1);
                end
            end
            S_FETCH_X: begin
                if (cnt_q == (num_act_q - len_bw'(1))) begin
                    state_d    = S_EXEC;
                    sram_cen_d = 1'b1;
                    inst_w_d   = issue_s ? 2'b10 : 2'b00;
                    l0_rd_d    = issue_s;
                    cnt_d      = {{(len_bw-1){1'b0}}, issue_s};
                end else begin
                    cnt_d       = cnt_q + len_bw'(1);
                    sram_addr_d = sram_addr_q + addr_bw'(1);
                end
            end
            S_EXEC: begin
                // cnt_q == num_act_q means the slot on the bus right now is the last one.
                if (cnt_q == num_act_q) begin
                    state_d  = S_WAIT_OUT;
                    inst_w_d = 2'b00;
                    l0_rd_d  = 1'b0;
                    cnt_d    = {len_bw{1'b0}};
`ifdef MAC_TILE_CTRL_WATCHDOG_EN
                    wd_d     = {wd_bw{1'b0}};
`endif
                end else begin
                    inst_w_d = issue_s ? 2'b10 : 2'b00;
                    l0_rd_d  = issue_s;
                    cnt_d    = cnt_q + {{(len_bw-1){1'b0}}, issue_s};
                end
            end
            S_WAIT_OUT: begin
                if (psum_q == num_act_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
`ifdef MAC_TILE_CTRL_WATCHDOG_EN
                    if (psum_inc_s) begin
                        wd_d = {wd_bw{1'b0}};
                    end else if (wd_q == wd_last) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        wd_d = wd_q + wd_bw'(1);
                    end
`else
                    state_d = S_WAIT_OUT;
`endif
                end
            end
            S_DONE: begin
                // A watchdog abort arrives with done low; raise it for one cycle first.
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= {len_bw{1'b0}};
            num_act_q   <= {len_bw{1'b0}};
            x_base_q    <= {addr_bw{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sram_cen_q  <= 1'b1;
            sram_addr_q <= {addr_bw{1'b0}};
            l0_wr_q     <= 1'b0;
            l0_rd_q     <= 1'b0;
            inst_w_q    <= 2'b00;
            psum_q      <= {len_bw{1'b0}};
            err_q       <= 1'b0;
`ifdef MAC_TILE_CTRL_WATCHDOG_EN
            wd_q        <= {wd_bw{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            num_act_q   <= num_act_d;
            x_base_q    <= x_base_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sram_cen_q  <= sram_cen_d;
            sram_addr_q <= sram_addr_d;
            l0_wr_q     <= l0_wr_d;
            l0_rd_q     <= l0_rd_d;
            inst_w_q    <= inst_w_d;
            psum_q      <= psum_d;
            err_q       <= err_d;
`ifdef MAC_TILE_CTRL_WATCHDOG_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sram_cen  = sram_cen_q;
    assign sram_addr = sram_addr_q;
    assign l0_wr     = l0_wr_q;
    assign l0_rd     = l0_rd_q;
    assign inst_w    = inst_w_q;
    assign psum_cnt  = psum_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mac_tile_ctrl.sv
// Directed bench for mac_tile_ctrl with address/psum scoreboards and a delay-line array model.
module tb_mac_tile_ctrl;

    localparam int ROW = 8, COL = 8, LEN_BW = 8, ADDR_BW = 11, LAT = ROW + COL;

    logic               clk = 1'b0;
    logic               reset, start, ofifo_full;
    logic [LEN_BW-1:0]  num_act;
    logic [ADDR_BW-1:0] w_base, x_base;
    logic [COL-1:0]     array_valid;
    logic               busy, done, sram_cen, l0_wr, l0_rd, err;
    logic [ADDR_BW-1:0] sram_addr;
    logic [1:0]         inst_w;
    logic [LEN_BW-1:0]  psum_cnt;

    logic [LAT-1:0] pipe = '0;
    logic           array_en = 1'b1;

    mac_tile_ctrl #(.row(ROW), .col(COL), .len_bw(LEN_BW), .addr_bw(ADDR_BW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_act(num_act), .w_base(w_base),
        .x_base(x_base), .ofifo_full(ofifo_full), .array_valid(array_valid), .busy(busy),
        .done(done), .sram_cen(sram_cen), .sram_addr(sram_addr), .l0_wr(l0_wr), .l0_rd(l0_rd),
        .inst_w(inst_w), .psum_cnt(psum_cnt), .err(err)
    );

    always #5 clk = ~clk;

    // Array model: each execute slot yields an output vector LAT cycles later.
    always_ff @(posedge clk) pipe <= {pipe[LAT-2:0], array_en && (inst_w == 2'b10)};
    assign array_valid = {pipe[LAT-1], {(COL-1){1'b0}}};

    int checks = 0, errors = 0;
    logic [ADDR_BW-1:0] addr_q[$];
    logic [LEN_BW-1:0]  psum_q[$];
    int cyc = 0, load_cnt = 0, drain_cnt = 0, exec_cnt = 0, done_cnt = 0, err_cnt = 0, read_cnt = 0;
    int first_exec_cyc = 0, last_exec_cyc = 0, err_cyc = 0, done_cyc = 0;
    logic in_exec = 1'b0, seen_load = 1'b0, prev_cen = 1'b1, prev_rst = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_rst) check("l0_wr_after_reset", l0_wr, 0);
            else          check("l0_wr_follows_cen", l0_wr, !prev_cen);
            check("l0_rd_with_inst", l0_rd, (inst_w != 2'b00));
            if (!sram_cen) begin
                read_cnt++;
                if (addr_q.size() == 0) check("unexpected_read", 1, 0);
                else                    check("sram_addr", sram_addr, addr_q.pop_front());
            end
            if (inst_w == 2'b01) begin load_cnt++; seen_load = 1'b1; end
            if (busy && inst_w == 2'b00 && sram_cen && seen_load && !in_exec) drain_cnt++;
            if (inst_w == 2'b10) begin
                exec_cnt++;
                if (!in_exec) first_exec_cyc = cyc;
                in_exec = 1'b1;
                last_exec_cyc = cyc;
            end
            if (!busy) begin in_exec = 1'b0; seen_load = 1'b0; end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (psum_q.size() == 0) check("unexpected_done", 1, 0);
                else                    check("psum_at_done", psum_cnt, psum_q.pop_front());
            end
            if (err) begin err_cnt++; err_cyc = cyc; end
            prev_cen = sram_cen;
            prev_rst = reset;
        end
    endtask

    task automatic push_tile(input int n, input logic [ADDR_BW-1:0] wb, input logic [ADDR_BW-1:0] xb);
        for (int k = 0; k < COL; k++) addr_q.push_back(wb + ADDR_BW'(k));
        for (int k = 0; k < n; k++)   addr_q.push_back(xb + ADDR_BW'(k));
    endtask

    task automatic pulse_start(input logic [LEN_BW-1:0] n, input logic [ADDR_BW-1:0] wb,
                               input logic [ADDR_BW-1:0] xb);
        @(posedge clk); #1;
        start = 1'b1; num_act = n; w_base = wb; x_base = xb;
        @(posedge clk); #1;
        start = 1'b0; num_act = 8'd0; w_base = 11'd0; x_base = 11'd0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int base = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cnt != base) break;
        end
        check(tag, (done_cnt != base), 1);
    endtask

    task automatic wait_exec(input int base, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (exec_cnt - base >= target) break;
        end
        check("exec_reached", (exec_cnt - base >= target), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cen"}, sram_cen, 1);
        check({tag, "_addr"}, sram_addr, 0);
        check({tag, "_l0_wr"}, l0_wr, 0);
        check({tag, "_l0_rd"}, l0_rd, 0);
        check({tag, "_inst"}, inst_w, 0);
        check({tag, "_psum"}, psum_cnt, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int b_load, b_drain, b_exec, b_done, b_read, b_err;
        reset = 1'b1; start = 1'b0; ofifo_full = 1'b0;
        num_act = 8'd0; w_base = 11'd0; x_base = 11'd0;
        fork monitor(); join_none
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_reset_values("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Normal tile, with an ignored start issued while busy.
        b_load = load_cnt; b_drain = drain_cnt; b_exec = exec_cnt; b_done = done_cnt;
        push_tile(36, 11'd0, 11'd16);
        psum_q.push_back(8'd36);
        pulse_start(8'd36, 11'd0, 11'd16);
        check("busy_after_start", busy, 1);
        check("cen_after_start", sram_cen, 0);
        repeat (15) @(posedge clk);
        pulse_start(8'd5, 11'd100, 11'd200);
        wait_done(400, "normal_done_timeout");
        check("normal_busy_at_done", busy, 0);
        repeat (3) @(posedge clk); #1;
        check("normal_load_cycles", load_cnt - b_load, 8);
        check("normal_drain_cycles", drain_cnt - b_drain, 8);
        check("normal_exec_cycles", exec_cnt - b_exec, 36);
        check("normal_exec_len", last_exec_cyc - first_exec_cyc + 1, 36);
        check("normal_done_pulses", done_cnt - b_done, 1);

        // Backpressure: five-cycle ofifo_full starting at slot 10.
        b_exec = exec_cnt; b_done = done_cnt;
        push_tile(36, 11'd0, 11'd16);
        psum_q.push_back(8'd36);
        pulse_start(8'd36, 11'd0, 11'd16);
        wait_exec(b_exec, 9, 200);
        ofifo_full = 1'b1;
        repeat (5) @(posedge clk);
        #2 ofifo_full = 1'b0;
        wait_done(400, "bp_done_timeout");
        repeat (2) @(posedge clk); #1;
        check("bp_exec_cycles", exec_cnt - b_exec, 36);
        check("bp_exec_len", last_exec_cyc - first_exec_cyc + 1, 41);
        check("bp_done_pulses", done_cnt - b_done, 1);

        // Degenerate start with num_act = 0.
        b_read = read_cnt; b_done = done_cnt;
        psum_q.push_back(8'd0);
        pulse_start(8'd0, 11'd5, 11'd9);
        check("zero_done_high", done, 1);
        check("zero_busy", busy, 0);
        check("zero_cen", sram_cen, 1);
        @(posedge clk); #1;
        check("zero_done_low", done, 0);
        repeat (2) @(posedge clk); #1;
        check("zero_no_reads", read_cnt - b_read, 0);
        check("zero_done_pulses", done_cnt - b_done, 1);

        // Reset during slot 20, then a short tile.
        b_exec = exec_cnt; b_done = done_cnt;
        push_tile(36, 11'd0, 11'd16);
        pulse_start(8'd36, 11'd0, 11'd16);
        wait_exec(b_exec, 20, 200);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values("midrst");
        reset = 1'b0;
        repeat (20) @(posedge clk); #1;
        check("midrst_no_done", done_cnt - b_done, 0);
        b_exec = exec_cnt;
        push_tile(4, 11'd0, 11'd16);
        psum_q.push_back(8'd4);
        pulse_start(8'd4, 11'd0, 11'd16);
        wait_done(200, "after_rst_done_timeout");
        check("after_rst_exec_cycles", exec_cnt - b_exec, 4);

        // Activation address wrap-around.
        b_read = read_cnt;
        push_tile(8, 11'd0, 11'd2044);
        psum_q.push_back(8'd8);
        pulse_start(8'd8, 11'd0, 11'd2044);
        wait_done(200, "wrap_done_timeout");
        check("wrap_reads", read_cnt - b_read, 16);
        check("no_err_so_far", err_cnt, 0);

        // No output vectors: watchdog abort or indefinite wait.
        array_en = 1'b0;
        b_err = err_cnt; b_done = done_cnt;
        push_tile(4, 11'd0, 11'd16);
`ifdef MAC_TILE_CTRL_WATCHDOG_EN
        psum_q.push_back(8'd0);
        pulse_start(8'd4, 11'd0, 11'd16);
        wait_done(300, "wd_done_timeout");
        check("wd_err_pulses", err_cnt - b_err, 1);
        check("wd_err_delay", err_cyc - last_exec_cyc, 33);
        check("wd_done_after_err", done_cyc - err_cyc, 1);
`else
        pulse_start(8'd4, 11'd0, 11'd16);
        repeat (210) @(posedge clk); #1;
        check("nowd_busy_held", busy, 1);
        check("nowd_err_quiet", err_cnt - b_err, 0);
        check("nowd_no_done", done_cnt - b_done, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("nowd_busy_cleared", busy, 0);
`endif
        repeat (3) @(posedge clk); #1;
        check("addr_queue_empty", addr_q.size(), 0);
        check("psum_queue_empty", psum_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
